ethernet_rx_filt: RTL

Parametrised successor to the current RMII receive top level. It handles N bits per clock and does all of the following internally: preamble/SFD hunt, byte assembly, destination-MAC filter (unicast, broadcast, promiscuous), 16-bit ethertype extraction and CRC-32 check. It also enforces runt and oversize limits and streams payload bytes with a 4-byte FCS strip. It sits between the PHY input pins and the IP/UDP parser; the frame verdict is given by an rx_done or rx_kill pulse with an error code.

---
 rtl/ethernet_rx_filt.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/ethernet_rx_filt.sv
// RMII-style receive front end: preamble hunt, byte assembly, MAC filter,
// ethertype, CRC-32 check, runt/oversize limits, FCS-stripped payload. Optional statistics: ETH_RX_STATS_EN.
module ethernet_rx_filt #(
  parameter int N         = 2,
  parameter int MAX_BYTES = 1518,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     axiid,
  input  logic             axiiv,
  input  logic [47:0]      mac,
  input  logic             promisc,
  output logic [7:0]       axiod,
  output logic             axiov,
  output logic [15:0]      ethertype,
  output logic             ethertype_valid,
  output logic             rx_done,
  output logic             rx_kill,
  output logic [1:0]       rx_err
`ifdef ETH_RX_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_good,
  output logic [CNT_W-1:0] stat_filtered,
  output logic [CNT_W-1:0] stat_runt,
  output logic [CNT_W-1:0] stat_oversize,
  output logic [CNT_W-1:0] stat_crc
`endif
);

  typedef enum logic [2:0] {WAIT_IDLE, HUNT, PRE, HDR, PAY, FIN, DROP} state_t;

  localparam logic [2:0]  LAST_BEAT = 3'(8 / N - 1);
  localparam logic [15:0] OVER_CNT  = 16'(MAX_BYTES + 1);
  localparam logic [31:0] CRC_RESID = 32'hDEBB20E3;

  state_t      state_reg;
  logic [7:0]  sr_reg;
  logic [2:0]  beat_reg;
  logic [15:0] byte_cnt_reg;
  logic [31:0] crc_reg;
  logic        uc_ok_reg;
  logic        bc_ok_reg;
  logic        ovr_reg;
  logic [7:0]  et_hi_reg;
  logic [7:0]  dl_reg [4];

  logic [7:0]  sr_next;
  logic [7:0]  mac_byte;
  logic [31:0] crc_next;
  logic [15:0] cnt_next;
  logic        byte_done;
  logic        dest_ok;
  logic        filt_now;

  // New symbols enter at the top so the first-received bits end up as the byte LSBs.
  generate
    if (N == 8) begin : g_sr8
      assign sr_next = axiid;
    end else begin : g_srn
      assign sr_next = {axiid, sr_reg[7:N]};
    end
  endgenerate

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    mac_byte = mac[7:0];
    case (byte_cnt_reg[2:0])
      3'd0:    mac_byte = mac[47:40];
      3'd1:    mac_byte = mac[39:32];
      3'd2:    mac_byte = mac[31:24];
      3'd3:    mac_byte = mac[23:16];
      3'd4:    mac_byte = mac[15:8];
      default: mac_byte = mac[7:0];
    endcase
  end

  assign crc_next  = crc_byte(crc_reg, sr_next);
  assign cnt_next  = byte_cnt_reg + 16'd1;
  assign byte_done = axiiv && (beat_reg == LAST_BEAT);
  assign dest_ok   = (uc_ok_reg && (sr_next == mac_byte)) ||
                     (bc_ok_reg && (sr_next == 8'hFF)) || promisc;
  assign filt_now  = (state_reg == HDR) && byte_done && (byte_cnt_reg == 16'd5) && !dest_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= WAIT_IDLE;
      sr_reg          <= '0;
      beat_reg        <= '0;
      byte_cnt_reg    <= '0;
      crc_reg         <= '0;
      uc_ok_reg       <= 1'b0;
      bc_ok_reg       <= 1'b0;
      ovr_reg         <= 1'b0;
      et_hi_reg       <= '0;
      for (int i = 0; i < 4; i++) dl_reg[i] <= '0;
      axiod           <= '0;
      axiov           <= 1'b0;
      ethertype       <= '0;
      ethertype_valid <= 1'b0;
      rx_done         <= 1'b0;
      rx_kill         <= 1'b0;
      rx_err          <= '0;
    end else begin
      axiov           <= 1'b0;
      ethertype_valid <= 1'b0;
      rx_done         <= 1'b0;
      rx_kill         <= 1'b0;
      rx_err          <= '0;
      case (state_reg)
        WAIT_IDLE: if (!axiiv) state_reg <= HUNT;
        HUNT: begin
          sr_reg <= '0;
          if (axiiv) state_reg <= PRE;
        end
        PRE: begin
          if (!axiiv) begin
            state_reg <= HUNT;
          end else begin
            sr_reg <= sr_next;
            if (sr_next == 8'hD5) begin
              state_reg    <= HDR;
              beat_reg     <= '0;
              byte_cnt_reg <= '0;
              crc_reg      <= 32'hFFFFFFFF;
              uc_ok_reg    <= 1'b1;
              bc_ok_reg    <= 1'b1;
              ovr_reg      <= 1'b0;
            end
          end
        end
        HDR, PAY: begin
          if (!axiiv) begin
            // Partial byte bits are simply dropped; the verdict uses whole bytes only.
            state_reg <= FIN;
            if (byte_cnt_reg < 16'd64) begin
              rx_kill <= 1'b1;
              rx_err  <= 2'd1;
            end else if (crc_reg != CRC_RESID) begin
              rx_kill <= 1'b1;
              rx_err  <= 2'd3;
            end else begin
              rx_done <= 1'b1;
            end
          end else begin
            sr_reg <= sr_next;
            if (beat_reg != LAST_BEAT) begin
              beat_reg <= beat_reg + 3'd1;
            end else begin
              beat_reg     <= '0;
              crc_reg      <= crc_next;
              byte_cnt_reg <= cnt_next;
              if (state_reg == HDR) begin
                if (byte_cnt_reg < 16'd6) begin
                  uc_ok_reg <= uc_ok_reg && (sr_next == mac_byte);
                  bc_ok_reg <= bc_ok_reg && (sr_next == 8'hFF);
                end
                if (filt_now) state_reg <= DROP;
                if (byte_cnt_reg == 16'd12) et_hi_reg <= sr_next;
                if (byte_cnt_reg == 16'd13) begin
                  ethertype       <= {et_hi_reg, sr_next};
                  ethertype_valid <= 1'b1;
                  state_reg       <= PAY;
                end
              end else if (cnt_next == OVER_CNT) begin
                state_reg <= DROP;
                ovr_reg   <= 1'b1;
              end else begin
                // Four-deep delay line keeps the trailing FCS from ever being emitted.
                if (byte_cnt_reg >= 16'd18) begin
                  axiod <= dl_reg[3];
                  axiov <= 1'b1;
                end
                dl_reg[0] <= sr_next;
                for (int i = 1; i < 4; i++) dl_reg[i] <= dl_reg[i-1];
              end
            end
          end
        end
        FIN: begin
          sr_reg    <= '0;
          state_reg <= axiiv ? PRE : HUNT;
        end
        DROP: begin
          if (!axiiv) begin
            state_reg <= HUNT;
            if (ovr_reg) begin
              rx_kill <= 1'b1;
              rx_err  <= 2'd2;
            end
          end
        end
        default: state_reg <= WAIT_IDLE;
      endcase
    end
  end

`ifdef ETH_RX_STATS_EN
  logic [4:0]       stat_ev;
  logic [CNT_W-1:0] stat_cnt [5];

  assign stat_ev = {rx_kill && (rx_err == 2'd3), rx_kill && (rx_err == 2'd2),
                    rx_kill && (rx_err == 2'd1), filt_now, rx_done};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stat
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          stat_cnt[gi] <= '0;
        else if (stat_ev[gi] && (stat_cnt[gi] != {CNT_W{1'b1}}))
          stat_cnt[gi] <= stat_cnt[gi] + 1'b1;
      end
    end
  endgenerate

  assign stat_good     = stat_cnt[0];
  assign stat_filtered = stat_cnt[1];
  assign stat_runt     = stat_cnt[2];
  assign stat_oversize = stat_cnt[3];
  assign stat_crc      = stat_cnt[4];
`else
  // CNT_W only sizes the statistics counters.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
